// File: rtl/link_pkg.sv
// Shared link-layer definitions: byte width and the four-state arbiter FSM encoding,
// common to the link master, slave and arbiter blocks.
package link_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FWD   = 2'd1,
        ACK   = 2'd2,
        DRAIN = 2'd3
    } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin winner search: first set request bit at or above ptr,
// wrapping modulo N. With ptr tied to zero it degenerates to fixed lowest-index priority.
module rr_picker #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         valid,
    output logic [W-1:0] idx
);

    logic [N-1:0] w_rot;
    logic [W-1:0] w_off;
    logic [W:0]   w_sum;

    // Rotate so that bit 0 of w_rot is requester ptr; ptr < N keeps this a true modulo rotate.
    assign w_rot = N'({req, req} >> ptr);

    always_comb begin
        w_off = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off = W'(k);
            end
        end
    end

    assign w_sum = {1'b0, ptr} + {1'b0, w_off};
    assign idx   = (w_sum >= (W + 1)'(N)) ? W'(w_sum - (W + 1)'(N)) : w_sum[W-1:0];
    assign valid = |req;

endmodule

// File: rtl/link_arbiter.sv
// N-to-1 four-phase link arbiter: grants one upstream requester, forwards its byte downstream,
// and relays the handshake. Define LINK_ARB_FIXED_PRIO_EN for fixed lowest-index priority.
module link_arbiter
    import link_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int GID_W = $clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        m_req,
    input  logic [DATA_W*N_REQ-1:0] m_data,
    output logic [N_REQ-1:0]        m_ack,
    output logic                    s_req,
    output logic [DATA_W-1:0]       s_data,
    input  logic                    s_ack,
    output logic [GID_W-1:0]        gnt_id,
    output logic                    busy,
    output logic                    xfer_done
);

    arb_state_t        r_state;
    logic [GID_W-1:0]  r_sel;
    logic [DATA_W-1:0] r_s_data;
    logic              r_s_req;
    logic [N_REQ-1:0]  r_m_ack;
    logic              r_busy;
    logic              r_xfer_done;

    logic [GID_W-1:0]  w_ptr;
    logic [GID_W-1:0]  w_idx;
    logic              w_valid;
    logic [N_REQ-1:0]  w_sel_onehot;
    logic [DATA_W-1:0] w_bytes [N_REQ];

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign w_bytes[gi] = m_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    assign w_sel_onehot = N_REQ'(1) << r_sel;

`ifdef LINK_ARB_FIXED_PRIO_EN
    assign w_ptr = '0;
`else
    logic [GID_W-1:0] r_ptr;

    // The search origin moves past the requester that just completed.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (r_state == DRAIN && !s_ack) begin
            r_ptr <= (r_sel == GID_W'(N_REQ - 1)) ? '0 : r_sel + 1'b1;
        end
    end

    assign w_ptr = r_ptr;
`endif

    rr_picker #(
        .N (N_REQ),
        .W (GID_W)
    ) u_picker (
        .req   (m_req),
        .ptr   (w_ptr),
        .valid (w_valid),
        .idx   (w_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_sel       <= '0;
            r_s_data    <= '0;
            r_s_req     <= 1'b0;
            r_m_ack     <= '0;
            r_busy      <= 1'b0;
            r_xfer_done <= 1'b0;
        end else begin
            r_xfer_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_valid) begin
                        r_sel    <= w_idx;
                        r_s_data <= w_bytes[w_idx];
                        r_s_req  <= 1'b1;
                        r_busy   <= 1'b1;
                        r_state  <= FWD;
                    end
                end
                FWD: begin
                    // An early m_req drop is deliberately not checked here; ACK resolves it.
                    if (s_ack) begin
                        r_m_ack <= w_sel_onehot;
                        r_state <= ACK;
                    end
                end
                ACK: begin
                    if (!m_req[r_sel]) begin
                        r_s_req <= 1'b0;
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!s_ack) begin
                        r_m_ack     <= '0;
                        r_busy      <= 1'b0;
                        r_xfer_done <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign m_ack     = r_m_ack;
    assign s_req     = r_s_req;
    assign s_data    = r_s_data;
    assign gnt_id    = r_sel;
    assign busy      = r_busy;
    assign xfer_done = r_xfer_done;

endmodule
